sha3_round_sequencer: RTL and testbench

- Drives one Keccak-f[1600] permutation through a single shared round datapath (theta, rho/pi, chi, iota chain) using a sample/good pulse handshake.
- Captures the input state and issues it to the round datapath once per round, together with the round index for the iota constant.
- Feeds each round result back as the next round's input; after NUM_ROUNDS rounds, presents the final state with a good pulse.
- A watchdog flags a round datapath that fails to return good.

---
 rtl/sha3_round_sequencer_if.sv | 29 ++
 rtl/sha3_round_sequencer.sv | 135 +++++++++++++
 tb/tb_sha3_round_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_round_sequencer_if.sv
// Handshake bundle between the SHA-3 round sequencer, its requester and the shared round datapath.
// Each row is five 64-bit lanes; lane 0 is index [0].
interface sha3_round_sequencer_if;
    logic                 start;
    logic [4:0][63:0]     isa, isb, isc, isd, ise;
    logic                 busy;
    logic [4:0][63:0]     rsa, rsb, rsc, rsd, rse;
    logic                 round_sample;
    logic [4:0]           round_index;
    logic [4:0][63:0]     rra, rrb, rrc, rrd, rre;
    logic                 round_good;
    logic [4:0][63:0]     osa, osb, osc, osd, ose;
    logic                 good;
    logic                 error;

    modport slave (
        input  start, isa, isb, isc, isd, ise,
        input  rra, rrb, rrc, rrd, rre, round_good,
        output busy, rsa, rsb, rsc, rsd, rse, round_sample, round_index,
        output osa, osb, osc, osd, ose, good, error
    );

    modport master (
        output start, isa, isb, isc, isd, ise,
        output rra, rrb, rrc, rrd, rre, round_good,
        input  busy, rsa, rsb, rsc, rsd, rse, round_sample, round_index,
        input  osa, osb, osc, osd, ose, good, error
    );
endinterface

// File: rtl/sha3_round_sequencer.sv
// Sequences one Keccak-f[1600] permutation through a shared single-round datapath,
// feeding each round result back and guarding every round with a watchdog.
module sha3_round_sequencer #(
    parameter int unsigned NUM_ROUNDS = 24,
    parameter int unsigned TIMEOUT    = 15
) (
    input logic                      clk,
    input logic                      rst,
    sha3_round_sequencer_if.slave    bus
);
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned WD_W   = 8;
    localparam int unsigned LANE_W = 64;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

    typedef logic [4:0][4:0][LANE_W-1:0] state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_ERROR
    } fsm_t;

    fsm_t             state_q, state_d;
    state_t           rs_q, rs_d;
    state_t           os_q, os_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             busy_q, busy_d;
    logic             sample_q, sample_d;
    logic             good_q, good_d;
    logic             error_q, error_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rs_q     <= '0;
            os_q     <= '0;
            idx_q    <= '0;
            wd_q     <= '0;
            busy_q   <= 1'b0;
            sample_q <= 1'b0;
            good_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rs_q     <= rs_d;
            os_q     <= os_d;
            idx_q    <= idx_d;
            wd_q     <= wd_d;
            busy_q   <= busy_d;
            sample_q <= sample_d;
            good_q   <= good_d;
            error_q  <= error_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they are registered.
    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        os_d    = os_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        error_d = error_q;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (bus.start) begin
                    rs_d    = {bus.ise, bus.isd, bus.isc, bus.isb, bus.isa};
                    idx_d   = '0;
                    error_d = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A returning round beats a watchdog expiry in the same cycle.
                if (bus.round_good) begin
                    rs_d = {bus.rre, bus.rrd, bus.rrc, bus.rrb, bus.rra};
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_ISSUE;
                    end
                end else if (wd_q == WD_LIMIT) begin
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_DONE) begin
            os_d = rs_d;
        end

        busy_d   = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_DONE);
        sample_d = (state_d == ST_ISSUE);
        good_d   = (state_d == ST_DONE);
    end

    assign bus.busy         = busy_q;
    assign bus.round_sample = sample_q;
    assign bus.round_index  = idx_q;
    assign bus.good         = good_q;
    assign bus.error        = error_q;

    assign bus.rsa = rs_q[0];
    assign bus.rsb = rs_q[1];
    assign bus.rsc = rs_q[2];
    assign bus.rsd = rs_q[3];
    assign bus.rse = rs_q[4];

    assign bus.osa = os_q[0];
    assign bus.osb = os_q[1];
    assign bus.osc = os_q[2];
    assign bus.osd = os_q[3];
    assign bus.ose = os_q[4];
endmodule

// File: tb/tb_sha3_round_sequencer.sv
// Scoreboard bench for sha3_round_sequencer with a behavioural round datapath that XORs the
// round index into lane 0 of row a after a fixed latency.
module tb_sha3_round_sequencer;
    localparam int NR = 24;
    localparam int TO = 15;
    localparam int L  = 4;

    typedef logic [4:0][4:0][63:0] st_t;
    typedef struct { st_t st; int cyc; } good_exp_t;
    typedef struct { int idx; int cyc; } samp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    good_exp_t good_q[$];
    samp_exp_t samp_q[$];

    int  drop_round = -1;
    bit  spurious   = 1'b0;
    st_t last_os    = '0;

    sha3_round_sequencer_if bus ();

    sha3_round_sequencer #(.NUM_ROUNDS(NR), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic st_t rs_now();
        return {bus.rse, bus.rsd, bus.rsc, bus.rsb, bus.rsa};
    endfunction

    function automatic st_t os_now();
        return {bus.ose, bus.osd, bus.osc, bus.osb, bus.osa};
    endfunction

    function automatic st_t rand_st();
        st_t s;
        for (int r = 0; r < 5; r++)
            for (int l = 0; l < 5; l++)
                s[r][l] = {$urandom, $urandom};
        return s;
    endfunction

    // Reference permutation: round r XORs r into lane 0 of row a.
    function automatic st_t ref_perm(st_t s);
        st_t t = s;
        for (int r = 0; r < NR; r++) t[0][0] = t[0][0] ^ 64'(r);
        return t;
    endfunction

    task automatic set_is(input st_t s);
        bus.isa = s[0]; bus.isb = s[1]; bus.isc = s[2]; bus.isd = s[3]; bus.ise = s[4];
    endtask

    task automatic set_rr(input st_t s);
        bus.rra = s[0]; bus.rrb = s[1]; bus.rrc = s[2]; bus.rrd = s[3]; bus.rre = s[4];
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_st(input string name, input st_t act, input st_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            for (int r = 0; r < 5; r++)
                for (int l = 0; l < 5; l++)
                    if (act[r][l] !== exp[r][l]) begin
                        $display("FAIL %s @cyc %0d row %0d lane %0d: got %0h expected %0h",
                                 name, cyc, r, l, act[r][l], exp[r][l]);
                        return;
                    end
        end
    endtask

    task automatic fail(input string name, input string detail);
        n_cmp++;
        n_fail++;
        $display("FAIL %s @cyc %0d: %s", name, cyc, detail);
    endtask

    // Issue a start at the current negedge; register the expected responses.
    task automatic do_start(input st_t s, input int nsamp, input bit expect_good, output int c);
        c = cyc;
        bus.start = 1'b1;
        set_is(s);
        for (int k = 0; k < nsamp; k++) samp_q.push_back('{idx: k, cyc: c + 1 + k * (L + 1)});
        if (expect_good) good_q.push_back('{st: ref_perm(s), cyc: c + 1 + NR * (L + 1)});
        @(negedge clk);
        bus.start = 1'b0;
        set_is(rand_st());
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (good_q.size() == 0 && samp_q.size() == 0 && !bus.busy) begin
                check("drain", 64'(good_q.size() + samp_q.size()), 64'd0);
                return;
            end
        end
        fail("drain_timeout", "expected responses never arrived");
    endtask

    task automatic wait_sample(input int idx, input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.round_sample && int'(bus.round_index) == idx) begin
                c = cyc;
                return;
            end
        end
        fail("sample_wait", $sformatf("round_sample for round %0d never seen", idx));
    endtask

    // Behavioural round datapath.
    initial begin
        st_t saved;
        int  due;
        bit  pend;
        saved = '0; due = 0; pend = 1'b0;
        bus.round_good = 1'b0;
        set_rr('0);
        forever begin
            @(negedge clk);
            bus.round_good = 1'b0;
            bus.rra[0] = {$urandom, $urandom};
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend && cyc == due) begin
                    bus.round_good = 1'b1;
                    set_rr(saved);
                    pend = 1'b0;
                end else if (spurious && $urandom_range(0, 1) == 1) begin
                    bus.round_good = 1'b1;
                end
                if (bus.round_sample) begin
                    saved       = rs_now();
                    saved[0][0] = saved[0][0] ^ 64'(bus.round_index);
                    due         = cyc + L;
                    pend        = (int'(bus.round_index) != drop_round);
                end
            end
        end
    end

    // Monitor: compares every round_sample and good against the scoreboard.
    initial begin
        samp_exp_t se;
        good_exp_t ge;
        forever begin
            @(negedge clk);
            if (!rst && bus.round_sample) begin
                if (samp_q.size() == 0) begin
                    fail("unexpected_sample", $sformatf("got round_sample=1 idx %0d expected none", bus.round_index));
                end else begin
                    se = samp_q.pop_front();
                    check("sample_idx", 64'(bus.round_index), 64'(se.idx));
                    check("sample_cycle", 64'(cyc), 64'(se.cyc));
                end
            end
            if (!rst && bus.good) begin
                if (good_q.size() == 0) begin
                    fail("unexpected_good", "got good=1 expected 0");
                end else begin
                    ge = good_q.pop_front();
                    check_st("final_state", os_now(), ge.st);
                    check("good_cycle", 64'(cyc), 64'(ge.cyc));
                    last_os = ge.st;
                end
            end
        end
    end

    initial begin
        int  c0, c1, s7, s10, g;
        st_t st;
        bus.start = 1'b0;
        set_is('0);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_error", 64'(bus.error), 64'd0);
        check("rst_index", 64'(bus.round_index), 64'd0);
        rst = 1'b0;

        // Idle with spurious round_good: nothing may happen.
        spurious = 1'b1;
        repeat (12) @(negedge clk);
        spurious = 1'b0;
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_good", 64'(bus.good), 64'd0);
        check("idle_error", 64'(bus.error), 64'd0);

        // All-zero state.
        @(negedge clk);
        do_start('0, NR, 1'b1, c0);
        check("issue_busy", 64'(bus.busy), 64'd1);
        wait_idle(300);
        check("zero_osa0", bus.osa[0], 64'd0);

        // Random state with a stray start 50 cycles in, then a back-to-back start.
        @(negedge clk);
        st = rand_st();
        do_start(st, NR, 1'b1, c0);
        while (cyc < c0 + 50) @(negedge clk);
        bus.start = 1'b1;
        set_is(rand_st());
        @(negedge clk);
        bus.start = 1'b0;
        g = -1;
        for (int i = 0; i < 300 && g < 0; i++) begin
            @(negedge clk);
            if (bus.good) g = cyc;
        end
        if (g < 0) fail("good_wait", "good never seen");
        @(negedge clk);
        check("busy_after_good", 64'(bus.busy), 64'd0);
        do_start(rand_st(), NR, 1'b1, c1);
        check("b2b_start_cycle", 64'(c1), 64'(g + 1));
        wait_idle(300);

        // Watchdog: round 7 never returns.
        drop_round = 7;
        @(negedge clk);
        do_start(rand_st(), 8, 1'b0, c0);
        wait_sample(7, 200, s7);
        repeat (TO) @(negedge clk);
        check("wd_not_yet", 64'(bus.error), 64'd0);
        @(negedge clk);
        check("wd_error", 64'(bus.error), 64'd1);
        check("wd_busy", 64'(bus.busy), 64'd0);
        check("wd_error_cycle", 64'(cyc - s7), 64'(TO + 1));
        repeat (10) @(negedge clk);
        check("wd_sticky", 64'(bus.error), 64'd1);
        check_st("wd_os_hold", os_now(), last_os);

        // Start from ERROR clears the flag and completes.
        drop_round = -1;
        do_start(rand_st(), NR, 1'b1, c0);
        check("err_cleared", 64'(bus.error), 64'd0);
        wait_idle(300);

        // Asynchronous reset in the middle of round 10.
        @(negedge clk);
        do_start(rand_st(), 11, 1'b0, c0);
        wait_sample(10, 200, s10);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_index", 64'(bus.round_index), 64'd0);
        check("arst_rsa0", bus.rsa[0], 64'd0);
        check_st("arst_os", os_now(), '0);
        good_q.delete();
        samp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (NR * (L + 1) + 10) @(negedge clk);
        check("post_rst_busy", 64'(bus.busy), 64'd0);
        check("post_rst_error", 64'(bus.error), 64'd0);
        check("final_queues", 64'(good_q.size() + samp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
